// File: rtl/mem_subsys_pkg.sv
// Shared types for the lower-cache line interface: request record, responder
// FSM states and the line-alignment helper.
package mem_subsys_pkg;

  localparam int LC_B          = 64;
  localparam int LC_PADDR_BITS = 22;
  localparam int LC_LINE_W     = 8 * LC_B;
  localparam int LC_OFF_W      = $clog2(LC_B);

  typedef struct packed {
    logic [LC_PADDR_BITS-1:0] paddr;
    logic                     we;
    logic [LC_LINE_W-1:0]     data;
  } lc_req_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } lc_resp_state_t;

  function automatic logic [LC_PADDR_BITS-1:0] line_align(input logic [LC_PADDR_BITS-1:0] addr);
    return {addr[LC_PADDR_BITS-1:LC_OFF_W], {LC_OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/lc_req_fifo.sv
// In-order request queue for the line responder; head is visible combinationally
// and pointers carry one extra bit so full and empty are distinguishable.
module lc_req_fifo
  import mem_subsys_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk_in,
  input  logic    rst_N_in,
  input  logic    push_in,
  input  lc_req_t data_in,
  input  logic    pop_in,
  output lc_req_t head_out,
  output logic    full_out,
  output logic    empty_out
);

  localparam int PW = $clog2(DEPTH);

  lc_req_t       mem [DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;

  assign empty_out = (wr_ptr == rd_ptr);
  assign full_out  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head_out  = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk_in) begin
    if (!rst_N_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_in && !full_out)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop_in && !empty_out)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage holds data only, so it is left out of reset.
  always_ff @(posedge clk_in) begin
    if (push_in && !full_out)
      mem[wr_ptr[PW-1:0]] <= data_in;
  end

endmodule

// File: rtl/lc_line_responder.sv
// Backing-store responder below the L1D: queues line reads and write-backs,
// services each after a fixed latency and returns read lines in order.
module lc_line_responder
  import mem_subsys_pkg::*;
#(
  parameter int B          = LC_B,
  parameter int PADDR_BITS = LC_PADDR_BITS,
  parameter int LINES      = 256,
  parameter int REQ_DEPTH  = 4,
  parameter int LATENCY    = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_N_in,
  input  logic                  hc_valid_in,
  output logic                  hc_ready_out,
  input  logic [PADDR_BITS-1:0] hc_addr_in,
  input  logic [8*B-1:0]        hc_value_in,
  input  logic                  hc_we_in,
  output logic                  hc_valid_out,
  input  logic                  hc_ready_in,
  output logic [PADDR_BITS-1:0] hc_addr_out,
  output logic [8*B-1:0]        hc_value_out,
  output logic                  busy_out
);

  localparam int OFF_W = $clog2(B);
  localparam int IDX_W = $clog2(LINES);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  lc_resp_state_t    state;
  logic [CNT_W-1:0]  cnt;
  lc_req_t           wrk;
  lc_req_t           fifo_in;
  lc_req_t           fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              store_we;
  logic [IDX_W-1:0]  idx;
  logic [8*B-1:0]    store [LINES];

  assign fifo_in      = '{paddr: hc_addr_in, we: hc_we_in, data: hc_value_in};
  assign hc_ready_out = !fifo_full;
  assign push         = hc_valid_in && !fifo_full;
  assign pop          = (state == IDLE) && !fifo_empty;
  assign busy_out     = !fifo_empty || (state != IDLE);
  assign idx          = wrk.paddr[OFF_W +: IDX_W];
  // Gated by reset so an in-flight write-back is dropped rather than committed.
  assign store_we     = rst_N_in && (state == WAIT) && (cnt == '0) && wrk.we;

  lc_req_fifo #(
    .DEPTH(REQ_DEPTH)
  ) u_fifo (
    .clk_in   (clk_in),
    .rst_N_in (rst_N_in),
    .push_in  (push),
    .data_in  (fifo_in),
    .pop_in   (pop),
    .head_out (fifo_head),
    .full_out (fifo_full),
    .empty_out(fifo_empty)
  );

  always_ff @(posedge clk_in) begin
    if (pop)
      wrk <= fifo_head;
  end

  always_ff @(posedge clk_in) begin
    if (store_we)
      store[idx] <= wrk.data;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_N_in) begin
      state        <= IDLE;
      cnt          <= '0;
      hc_valid_out <= 1'b0;
      hc_addr_out  <= '0;
      hc_value_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            cnt   <= CNT_W'(LATENCY - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            if (wrk.we) begin
              state <= IDLE;
            end else begin
              hc_value_out <= store[idx];
              hc_addr_out  <= line_align(wrk.paddr);
              hc_valid_out <= 1'b1;
              state        <= RESP;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (hc_ready_in) begin
            hc_valid_out <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lc_line_responder.sv
// Scoreboard bench for lc_line_responder: a reference line store predicts every
// read response, which is compared in order as the DUT hands it over.
module tb_lc_line_responder;

  localparam int B          = 64;
  localparam int PADDR_BITS = 22;
  localparam int LINES      = 256;
  localparam int REQ_DEPTH  = 4;
  localparam int LATENCY    = 4;
  localparam int LW         = 8 * B;

  logic                  clk_in = 1'b0;
  logic                  rst_N_in;
  logic                  hc_valid_in;
  logic                  hc_ready_out;
  logic [PADDR_BITS-1:0] hc_addr_in;
  logic [LW-1:0]         hc_value_in;
  logic                  hc_we_in;
  logic                  hc_valid_out;
  logic                  hc_ready_in;
  logic [PADDR_BITS-1:0] hc_addr_out;
  logic [LW-1:0]         hc_value_out;
  logic                  busy_out;

  typedef struct {
    logic [PADDR_BITS-1:0] addr;
    logic [LW-1:0]         data;
  } exp_t;

  exp_t          sb[$];
  logic [LW-1:0] model [LINES];
  int            n_checks = 0;
  int            n_errors = 0;

  lc_line_responder #(
    .B(B), .PADDR_BITS(PADDR_BITS), .LINES(LINES), .REQ_DEPTH(REQ_DEPTH), .LATENCY(LATENCY)
  ) dut (
    .clk_in      (clk_in),
    .rst_N_in    (rst_N_in),
    .hc_valid_in (hc_valid_in),
    .hc_ready_out(hc_ready_out),
    .hc_addr_in  (hc_addr_in),
    .hc_value_in (hc_value_in),
    .hc_we_in    (hc_we_in),
    .hc_valid_out(hc_valid_out),
    .hc_ready_in (hc_ready_in),
    .hc_addr_out (hc_addr_out),
    .hc_value_out(hc_value_out),
    .busy_out    (busy_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int line_of(input logic [PADDR_BITS-1:0] a);
    return int'((a / B) % LINES);
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [PADDR_BITS-1:0] a, input logic we,
                      input logic [LW-1:0] d, input bit track);
    int t = 0;
    hc_valid_in = 1'b1;
    hc_addr_in  = a;
    hc_we_in    = we;
    hc_value_in = d;
    while (!hc_ready_out && t < 200) begin
      @(negedge clk_in);
      t++;
    end
    if (!hc_ready_out) begin
      chk("accept_timeout", 0, 1);
      hc_valid_in = 1'b0;
      return;
    end
    @(posedge clk_in);
    if (track) begin
      if (we) model[line_of(a)] = d;
      else    sb.push_back('{a & ~PADDR_BITS'(B - 1), model[line_of(a)]});
    end
    @(negedge clk_in);
    hc_valid_in = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy_out || sb.size() != 0) && t < 500) begin
      @(negedge clk_in);
      t++;
    end
    chk("drain", LW'(busy_out || sb.size() != 0), 0);
  endtask

  always begin : monitor
    exp_t e;
    @(negedge clk_in);
    #1;
    if (rst_N_in === 1'b1 && hc_valid_out === 1'b1 && hc_ready_in === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("resp_addr", LW'(hc_addr_out), LW'(e.addr));
        chk("resp_data", hc_value_out, e.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    logic [PADDR_BITS-1:0] a_hold;
    logic [LW-1:0]         d_hold;
    logic [LW-1:0]         d;

    for (int i = 0; i < LINES; i++) model[i] = '0;
    rst_N_in    = 1'b0;
    hc_valid_in = 1'b0;
    hc_addr_in  = '0;
    hc_value_in = '0;
    hc_we_in    = 1'b0;
    hc_ready_in = 1'b1;
    repeat (3) @(negedge clk_in);
    rst_N_in = 1'b1;

    chk("rst_ready", LW'(hc_ready_out), 1);
    chk("rst_busy", LW'(busy_out), 0);
    chk("rst_valid", LW'(hc_valid_out), 0);
    chk("rst_addr", LW'(hc_addr_out), 0);
    chk("rst_value", hc_value_out, 0);

    // Read miss: latency and zero data
    send(22'h000040, 1'b0, '0, 1'b1);
    n = 0;
    while (!hc_valid_out && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    chk("read_miss_latency", LW'(n), LW'(LATENCY + 1));
    chk("read_miss_addr", LW'(hc_addr_out), LW'(22'h000040));
    chk("read_miss_value", hc_value_out, '0);
    @(negedge clk_in);
    chk("valid_one_cycle", LW'(hc_valid_out), 0);
    wait_idle();

    // Write-back then read of same line at a different offset
    send(22'h0000C0, 1'b1, {B{8'hA5}}, 1'b1);
    send(22'h0000C8, 1'b0, '0, 1'b1);
    wait_idle();
    chk("wb_model_line", model[3], {B{8'hA5}});

    // FIFO full under response backpressure
    hc_ready_in = 1'b0;
    for (int k = 0; k < 5; k++) send(PADDR_BITS'(22'h000100 + k * 64), 1'b0, '0, 1'b1);
    chk("fifo_full_ready", LW'(hc_ready_out), 0);
    repeat (3) @(negedge clk_in);
    chk("fifo_full_hold", LW'(hc_ready_out), 0);
    fork
      send(22'h000240, 1'b0, '0, 1'b1);
      begin
        repeat (5) @(negedge clk_in);
        chk("sixth_stalled", LW'(hc_ready_out), 0);
        hc_ready_in = 1'b1;
      end
    join
    wait_idle();

    // Response backpressure: outputs stable for 10 cycles
    d = rnd_line();
    send(22'h0001C0, 1'b1, d, 1'b1);
    hc_ready_in = 1'b0;
    send(22'h0001D4, 1'b0, '0, 1'b1);
    n = 0;
    while (!hc_valid_out && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    a_hold = hc_addr_out;
    d_hold = hc_value_out;
    chk("bp_data", d_hold, d);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_in);
      chk("bp_valid", LW'(hc_valid_out), 1);
      chk("bp_addr", LW'(hc_addr_out), LW'(a_hold));
      chk("bp_value", hc_value_out, d_hold);
    end
    hc_ready_in = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    chk("bp_released", LW'(hc_valid_out), 0);
    chk("bp_one_transfer", LW'(sb.size()), 0);
    wait_idle();

    // Address wrap modulo LINES*B
    d = rnd_line();
    send(PADDR_BITS'(LINES * B), 1'b1, d, 1'b1);
    send(22'h000000, 1'b0, '0, 1'b1);
    wait_idle();
    chk("wrap_model", model[0], d);

    // Mixed random traffic
    for (int k = 0; k < 10; k++) begin
      send(PADDR_BITS'($urandom_range(0, 32'h7FFF)), 1'($urandom_range(0, 1)), rnd_line(), 1'b1);
    end
    wait_idle();

    // Reset while the first of three reads is in WAIT
    send(22'h000040, 1'b0, '0, 1'b0);
    send(22'h000080, 1'b0, '0, 1'b0);
    send(22'h0000C0, 1'b0, '0, 1'b0);
    chk("pre_reset_busy", LW'(busy_out), 1);
    rst_N_in = 1'b0;
    @(negedge clk_in);
    rst_N_in = 1'b1;
    chk("post_reset_busy", LW'(busy_out), 0);
    chk("post_reset_ready", LW'(hc_ready_out), 1);
    chk("post_reset_valid", LW'(hc_valid_out), 0);
    chk("post_reset_addr", LW'(hc_addr_out), 0);
    chk("post_reset_value", hc_value_out, 0);
    repeat (30) @(negedge clk_in);
    chk("post_reset_quiet", LW'(hc_valid_out), 0);
    chk("post_reset_idle", LW'(busy_out), 0);

    // Store survives reset and service resumes
    send(22'h0000C0, 1'b0, '0, 1'b1);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
